// File: rtl/iir_sample_pacer.sv
// iir_sample_pacer
//
// Sample-rate pacer for the time-multiplexed IIR second-order sections.
// Samples arrive on a valid/ready stream and land in a small FIFO. They are
// re-emitted as one-cycle dv_out strobes spaced at least Nspace clocks apart.
// A one-cycle late pulse, plus a saturating counter, flags each output slot
// that passes while the FIFO is empty. Data passes through bit-exact.
//
// Ports
//   clk       sole clock
//   reset     synchronous, active-high reset
//   s_valid   input sample valid
//   s_ready   pacer can accept a sample (combinational from registered level)
//   s_data    input sample, two's complement [Ndint-1:-Ndfrac]
//   dv_out    one-cycle strobe: d_out holds a new sample
//   d_out     last emitted sample, held between strobes
//   level     current FIFO occupancy
//   late      one-cycle pulse: an output slot passed with the FIFO empty
//   late_cnt  saturating count of late pulses since reset
module iir_sample_pacer #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int Nspace = 6,
    parameter int Ndepth = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [Ndint-1:-Ndfrac]      s_data,
    output logic                        dv_out,
    output logic [Ndint-1:-Ndfrac]      d_out,
    output logic [$clog2(Ndepth+1)-1:0] level,
    output logic                        late,
    output logic [15:0]                 late_cnt
);
    localparam int LW = $clog2(Ndepth + 1);
    localparam int PW = $clog2(Ndepth);
    localparam int GW = $clog2(Nspace + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(Ndepth);
    localparam logic [GW-1:0] GAP_SAT    = GW'(Nspace);
    localparam logic [GW-1:0] GAP_FIRE   = GW'(Nspace - 1);
    localparam logic [GW:0]   NSP_EXT    = (GW + 1)'(Nspace);

    typedef logic [Ndint-1:-Ndfrac] sample_t;

    sample_t         mem_q [Ndepth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            primed_q, primed_d;
    logic            dv_q, dv_d;
    sample_t         dout_q, dout_d;
    logic            late_q, late_d;
    logic [15:0]     late_cnt_q, late_cnt_d;

    logic wr_en, gap_ok, pop, miss;

    assign s_ready = (level_q != LEVEL_FULL);
    assign wr_en   = s_valid && s_ready;

    // gap >= Nspace-1, written as gap+1 >= Nspace so it stays a real
    // comparison when Nspace is 1 (every cycle is then an output slot).
    assign gap_ok = ({1'b0, gap_q} + (GW + 1)'(1)) >= NSP_EXT;

    // Only registered occupancy gates the pop, so a sample written at an
    // edge is never emitted before the following cycle.
    assign pop  = (level_q != '0) && gap_ok;

    // gap passes through Nspace-1 once per emitted sample and then saturates,
    // so an arbitrarily long idle period reports exactly one miss.
    assign miss = primed_q && (gap_q == GAP_FIRE) && (level_q == '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        gap_d      = gap_q;
        primed_d   = primed_q;
        dv_d       = 1'b0;
        dout_d     = dout_q;
        late_d     = miss;
        late_cnt_d = late_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dv_d     = 1'b1;
            dout_d   = mem_q[rd_ptr_q];
            primed_d = 1'b1;
            gap_d    = '0;
        end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + GW'(1);
        end

        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LW'(1);
        end

        if (miss && (late_cnt_q != 16'hFFFF)) begin
            late_cnt_d = late_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_q      <= GAP_SAT;
            primed_q   <= 1'b0;
            dv_q       <= 1'b0;
            dout_q     <= '0;
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            gap_q      <= gap_d;
            primed_q   <= primed_d;
            dv_q       <= dv_d;
            dout_q     <= dout_d;
            late_q     <= late_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign dv_out   = dv_q;
    assign d_out    = dout_q;
    assign level    = level_q;
    assign late     = late_q;
    assign late_cnt = late_cnt_q;

endmodule
